ex_div_ctrl: RTL and testbench

- Multi-cycle divide sequencer for the EX stage. It takes over DIV/DIVU operands that the single-cycle ALU cannot complete in one cycle.
- Runs a radix-2 restoring division, one quotient bit per cycle, and raises a stall request so EX and earlier stages hold.
- Returns a 64-bit {remainder, quotient} to EX for HI/LO writeback.
- Arbitrates one shared divider between successive EX requests with a start/ready handshake and an annul input for flushes.

---
 rtl/ex_div_ctrl_pkg.sv | 18 +
 rtl/ex_div_ctrl_div_step.sv | 23 ++
 rtl/ex_div_ctrl.sv | 142 ++++++++++++++
 tb/tb_ex_div_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage divide sequencer: FSM states and handshake levels.
package ex_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int DOUBLE_REG_BUS_W = 64;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One radix-2 restoring-division iteration: trial subtract of the divisor from the
// partial remainder window, then shift in the next quotient bit.
module ex_div_ctrl_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]   i_work,
  input  logic [DATA_W-1:0]   i_divisor,
  output logic [2*DATA_W:0]   o_work
);

  logic [DATA_W:0] w_diff;
  logic            w_unused;

  // The top bit of the working register is always zero after a step; it is carried
  // only to keep the window arithmetic one bit wider than the remainder.
  assign w_unused = i_work[2*DATA_W];

  assign w_diff = i_work[2*DATA_W-1:DATA_W-1] - {1'b0, i_divisor};

  assign o_work = w_diff[DATA_W] ? {i_work[2*DATA_W-1:0], 1'b0}
                                 : {1'b0, w_diff[DATA_W-1:0], i_work[DATA_W-2:0], 1'b1};

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for EX: one quotient bit per cycle, stall request
// while busy, {remainder, quotient} returned through a start/ready handshake.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  div_state_e          r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W:0]   r_work, w_work_step;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_sign1, r_sign2, r_signed;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_accept, w_cnt_done, w_div_zero;
  logic [DATA_W-1:0]   w_abs1, w_abs2, w_quot, w_rem, w_quot_fix, w_rem_fix;

  assign w_accept   = (start_i == DIV_START) & ~annul_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_cnt_done = (r_cnt == CNT_W'(DATA_W));

  assign w_abs1 = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign w_quot     = r_work[DATA_W-1:0];
  assign w_rem      = r_work[2*DATA_W-1:DATA_W];
  assign w_quot_fix = (r_signed & (r_sign1 ^ r_sign2)) ? -w_quot : w_quot;
  assign w_rem_fix  = (r_signed & r_sign1) ? -w_rem : w_rem;

  ex_div_ctrl_div_step #(.DATA_W(DATA_W)) u_div_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_work_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    stallreq_o   = 1'b0;
    case (r_state)
      DIV_FREE: begin
        stallreq_o = w_accept;
        if (w_accept) begin
          w_state_next = w_div_zero ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        stallreq_o   = 1'b1;
        w_state_next = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        stallreq_o = 1'b1;
        if (annul_i) begin
          w_state_next = DIV_FREE;
        end else if (w_cnt_done) begin
          w_state_next = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_next = DIV_FREE;
        end
      end
      default: w_state_next = DIV_FREE;
    endcase
  end

  // Datapath: operand capture on acceptance, iteration, and result/ready registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_signed  <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (w_accept && !w_div_zero) begin
            r_cnt     <= '0;
            r_work    <= {{(DATA_W+1){1'b0}}, w_abs1};
            r_divisor <= w_abs2;
            r_sign1   <= opdata1_i[DATA_W-1];
            r_sign2   <= opdata2_i[DATA_W-1];
            r_signed  <= signed_i;
          end
        end
        DIV_BY_ZERO: begin
          if (!annul_i) begin
            r_result <= '0;
            r_ready  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (!annul_i) begin
            if (w_cnt_done) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= DIV_RESULT_READY;
            end else begin
              r_work <= w_work_step;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            r_ready <= DIV_RESULT_NOT_READY;
          end
        end
        default: r_ready <= DIV_RESULT_NOT_READY;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: expected results are queued when a divide is
// issued and compared when ready_o rises.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Issue one divide (called just after a falling edge), wait for ready, check the
  // popped expectation, optionally hold start in DONE, then release the handshake.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold);
    int          lat;
    logic [63:0] exp;
    start_i   = 1'b1;
    annul_i   = 1'b0;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    exp_q.push_back(ref_div(a, b, s));
    #1;
    chk("stall_idle_req", {63'd0, stallreq_o}, 64'd1);
    lat = -1;
    while (lat <= 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (ready_o) break;
      chk("stall_busy", {63'd0, stallreq_o}, 64'd1);
    end
    exp = exp_q.pop_front();
    if (!ready_o) begin
      chk("ready_timeout", {63'd0, ready_o}, 64'd1);
    end else begin
      $display("div %h / %h signed=%0d -> %h after %0d edges", a, b, s, result_o, lat);
      chk("result", result_o, exp);
      if (b == 32'd0) chk("latency_byzero", {63'd0, (lat <= 2)}, 64'd1);
      else            chk("latency", 64'(lat), 64'd33);
      chk("stall_done", {63'd0, stallreq_o}, 64'd0);
      opdata1_i = ~a;
      opdata2_i = 32'd0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_result", result_o, exp);
        chk("hold_ready", {63'd0, ready_o}, 64'd1);
      end
      start_i = 1'b0;
      @(negedge clk);
      chk("drop_ready", {63'd0, ready_o}, 64'd0);
      chk("drop_result_kept", result_o, exp);
      chk("drop_stall", {63'd0, stallreq_o}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 5);
    run_div(32'hFFFFFFF9, 32'h00000002, 1'b1, 0);
    run_div(32'h00000007, 32'hFFFFFFFE, 1'b1, 0);
    run_div(32'h12345678, 32'd0, 1'b0, 2);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);

    // Annul part-way through a run: no ready, then a fresh request completes normally.
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (11) begin
      @(negedge clk);
      chk("annul_no_ready", {63'd0, ready_o}, 64'd0);
    end
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("annul_quiet", {63'd0, ready_o}, 64'd0);
    end
    run_div(32'd100, 32'd7, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> (i * 5);
      s = i[0];
      if (b == 32'd0) b = 32'd1;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      run_div(a, b, s, 0);
    end

    // Synchronous reset in the middle of a run clears everything.
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'd3;
    repeat (15) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("midrun_rst_result", result_o, 64'd0);
    chk("midrun_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrun_rst_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
